// File: rtl/axi_pkg.sv
// Shared AXI write-side types: burst encodings, response codes, controller states.
package axi_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'b00,
        INCR   = 2'b01,
        WRAP4  = 2'b10,
        INCR4  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

    // Number of beats a burst carries; AWLEN only matters for INCR.
    function automatic logic [4:0] burst_beats(input burst_t burst, input logic [3:0] len);
        logic [4:0] n;
        case (burst)
            SINGLE:  n = 5'd1;
            INCR:    n = {1'b0, len} + 5'd1;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address generator shared by the read and write burst controllers.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  burst_t            burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;

    // Step by 2^size; WRAP4 keeps the upper bits of a 4-beat aligned window.
    always_comb begin
        step      = ADDR_W'(1) << size;
        wrap_mask = (step << 2) - ADDR_W'(1);
        incr_addr = addr + step;
        case (burst)
            SINGLE:  next_addr = addr;
            WRAP4:   next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_burst_ctrl.sv
// AXI slave write controller: one burst at a time, AW -> W beats -> B response,
// with beats steered onto a registered byte-strobed memory write port.
module axi_wr_burst_ctrl
    import axi_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ID_W      = 8,
    parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
    parameter int unsigned       MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam logic [2:0]  MAX_SIZE = 3'($clog2(STRB_W));

    wr_state_t           state_q,     state_d;
    logic                awready_q,   awready_d;
    logic                wready_q,    wready_d;
    logic                bvalid_q,    bvalid_d;
    logic [ID_W-1:0]     bid_q,       bid_d;
    resp_t               bresp_q,     bresp_d;
    logic [ID_W-1:0]     id_q,        id_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [2:0]          size_q,      size_d;
    burst_t              burst_q,     burst_d;
    logic [4:0]          beats_q,     beats_d;
    logic                dec_err_q,   dec_err_d;
    logic                slv_err_q,   slv_err_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [ADDR_W-1:0]   next_addr;
    logic                last_pos;
    logic                dec_now;
    logic                slv_now;

    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - MEM_BASE;
        return (a >= MEM_BASE) && (off < ADDR_W'(MEM_BYTES));
    endfunction

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Next-state logic for the burst sequencer, error flags and memory port.
    always_comb begin
        state_d     = state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beats_d     = beats_q;
        dec_err_d   = dec_err_q;
        slv_err_d   = slv_err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        last_pos    = (beats_q == 5'd1);
        // Errors seen on the current beat count immediately, so the beat
        // that raises a flag is itself kept off the memory port.
        dec_now     = dec_err_q || !in_window(addr_q);
        slv_now     = slv_err_q || (WID != id_q) || (WLAST != last_pos);

        case (state_q)
            IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    id_d      = AWID;
                    addr_d    = AWADDR;
                    size_d    = AWSIZE;
                    burst_d   = burst_t'(AWBURST);
                    beats_d   = burst_beats(burst_t'(AWBURST), AWLEN);
                    dec_err_d = !in_window(AWADDR);
                    slv_err_d = (AWSIZE > MAX_SIZE);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (WVALID && wready_q) begin
                    dec_err_d   = dec_now;
                    slv_err_d   = slv_now;
                    mem_we_d    = !(dec_now || slv_now);
                    mem_addr_d  = addr_q - MEM_BASE;
                    mem_wdata_d = WDATA;
                    mem_wstrb_d = WSTRB;
                    addr_d      = next_addr;
                    beats_d     = beats_q - 5'd1;
                    if (WLAST || last_pos) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = dec_now ? DECERR : (slv_now ? SLVERR : OKAY);
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= OKAY;
            id_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            burst_q     <= SINGLE;
            beats_q     <= '0;
            dec_err_q   <= 1'b0;
            slv_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beats_q     <= beats_d;
            dec_err_q   <= dec_err_d;
            slv_err_q   <= slv_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
